spi_cmd_dispatch: RTL

Downstream consumer of the SPI command queue. It pops one show-ahead queue entry and latches it in the pop cycle. It issues the primary SPI transaction to the SPI master on the following cycle, then expands the entry's chain-write fields into one extra write transaction per set mask bit. Per-transaction results go out on a response port, and a watchdog aborts transactions the master never completes.

---
 rtl/spi_cmd_dispatch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_cmd_dispatch.sv
// Pops one command-queue entry, issues its primary SPI transaction, then one
// CW_OP write per set chain-write mask bit, in ascending slot order.
module spi_cmd_dispatch #(
  parameter int unsigned N_DEV       = 4,
  parameter logic [2:0]  CW_OP       = 3'd2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [2:0]            q_op,
  input  logic [9:0]            q_addr,
  input  logic [12:0]           q_low13,
  input  logic [47:0]           q_wdata,
  input  logic [59:0]           q_std,
  input  logic [N_DEV-1:0]      q_cw_mask,
  input  logic [10*N_DEV-1:0]   q_cw_addr,
  input  logic [48*N_DEV-1:0]   q_cw_wdata,
  output logic                  spi_start,
  output logic [2:0]            spi_op,
  output logic [9:0]            spi_addr,
  output logic [12:0]           spi_low13,
  output logic [47:0]           spi_wdata,
  output logic [59:0]           spi_std,
  input  logic                  spi_busy,
  input  logic                  spi_done,
  input  logic [47:0]           spi_rdata,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_op,
  output logic [9:0]            rsp_addr,
  output logic [47:0]           rsp_rdata,
  output logic                  rsp_chain,
  output logic                  err_timeout,
  output logic                  idle
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  localparam bit          WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT_CYC - 1) : '0;

  state_t                state, state_nxt;
  logic [N_DEV-1:0]      rem_mask;
  logic [N_DEV-1:0]      low_bit;
  logic [10*N_DEV-1:0]   cw_addr_sh;
  logic [48*N_DEV-1:0]   cw_wdata_sh;
  logic [9:0]            nxt_addr;
  logic [47:0]           nxt_wdata;
  logic                  rsp_chain_r;
  logic [15:0]           wd_cnt;
  logic                  timeout_hit;

  // Lowest pending chain slot, one-hot, then mux its shadowed fields.
  always_comb begin
    low_bit   = rem_mask & (-rem_mask);
    nxt_addr  = '0;
    nxt_wdata = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (low_bit[i]) begin
        nxt_addr  = cw_addr_sh[10*i +: 10];
        nxt_wdata = cw_wdata_sh[48*i +: 48];
      end
    end
  end

  // spi_done takes priority over a coincident watchdog expiry.
  assign timeout_hit = WD_EN && (state == WAIT) && !spi_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (q_valid) state_nxt = START;
      START:   if (!spi_busy) state_nxt = WAIT;
      WAIT: begin
        if (spi_done)         state_nxt = (rem_mask != '0) ? START : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_ready   = (state == IDLE);
    idle      = (state == IDLE);
    spi_start = (state == START) && !spi_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_op      <= '0;
      spi_addr    <= '0;
      spi_low13   <= '0;
      spi_wdata   <= '0;
      spi_std     <= '0;
      rem_mask    <= '0;
      cw_addr_sh  <= '0;
      cw_wdata_sh <= '0;
      rsp_chain_r <= 1'b0;
      wd_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_addr    <= '0;
      rsp_rdata   <= '0;
      rsp_chain   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (q_valid) begin
            spi_op      <= q_op;
            spi_addr    <= q_addr;
            spi_low13   <= q_low13;
            spi_wdata   <= q_wdata;
            spi_std     <= q_std;
            rem_mask    <= q_cw_mask;
            cw_addr_sh  <= q_cw_addr;
            cw_wdata_sh <= q_cw_wdata;
            rsp_chain_r <= 1'b0;
          end
        end
        START: begin
          if (!spi_busy) wd_cnt <= '0;
        end
        WAIT: begin
          if (spi_done) begin
            rsp_valid <= 1'b1;
            rsp_op    <= spi_op;
            rsp_addr  <= spi_addr;
            rsp_rdata <= spi_rdata;
            rsp_chain <= rsp_chain_r;
            if (rem_mask != '0) begin
              rem_mask    <= rem_mask & ~low_bit;
              spi_op      <= CW_OP;
              spi_addr    <= nxt_addr;
              spi_wdata   <= nxt_wdata;
              rsp_chain_r <= 1'b1;
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            rem_mask    <= '0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
